ysyx_22040632_mem_arbiter: RTL and testbench

YSYX_22040632_MEM_ARBITER -- requirements
Module: ysyx_22040632_mem_arbiter

---
 rtl/ysyx_22040632_riscv_pkg.sv | 18 +
 rtl/ysyx_22040632_mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_22040632_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, AXI encodings, width defaults.
package ysyx_22040632_riscv_pkg;

  localparam int unsigned ArbAddrW = 32;
  localparam int unsigned ArbDataW = 64;

  localparam logic [1:0] AxiRespOkay = 2'b00;
  localparam logic [2:0] AxiSize8B   = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrA,
    StWrB
  } arb_state_e;

endpackage

// File: rtl/ysyx_22040632_mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and load-store onto one AXI master port.
// Optional round-robin on contested grants: define YSYX_22040632_ARB_RR_EN.
module ysyx_22040632_mem_arbiter
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = ArbAddrW,
  parameter int unsigned DATA_W = ArbDataW
) (
  input  logic                clk,
  input  logic                rrst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  input  logic                if_kill,
  output logic                if_rsp_valid,
  output logic                if_rsp_err,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_req_we,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [2:0]          ls_req_size,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_rsp_valid,
  output logic                ls_rsp_err,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arsize,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awsize,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp
);

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                fetch_q, fetch_d;
  logic                kill_q, kill_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic                ls_rsp_valid_q, ls_rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                grant_if, grant_ls;

`ifdef YSYX_22040632_ARB_RR_EN
  // 1 means load-store won the most recent grant, so fetch wins the next contest.
  logic last_ls_q;
`endif

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == StIdle && !rrst) begin
      if (if_req_valid && ls_req_valid) begin
`ifdef YSYX_22040632_ARB_RR_EN
        grant_if = last_ls_q;
        grant_ls = !last_ls_q;
`else
        grant_ls = 1'b1;
`endif
      end else begin
        grant_if = if_req_valid;
        grant_ls = ls_req_valid;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    size_d         = size_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    fetch_d        = fetch_q;
    kill_d         = kill_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    rsp_err_d      = rsp_err_q;
    rsp_data_d     = rsp_data_q;
    if_rsp_valid_d = 1'b0;
    ls_rsp_valid_d = 1'b0;
    m_arvalid      = 1'b0;
    m_rready       = 1'b0;
    m_awvalid      = 1'b0;
    m_wvalid       = 1'b0;
    m_bready       = 1'b0;

    unique case (state_q)
      StIdle: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (grant_ls) begin
          addr_d  = ls_req_addr;
          size_d  = ls_req_size;
          wdata_d = ls_req_wdata;
          wstrb_d = ls_req_wstrb;
          fetch_d = 1'b0;
          kill_d  = 1'b0;
          state_d = ls_req_we ? StWrA : StRdA;
        end else if (grant_if) begin
          addr_d  = if_req_addr & ~ADDR_W'(3'h7);
          size_d  = AxiSize8B;
          wdata_d = '0;
          wstrb_d = '0;
          fetch_d = 1'b1;
          kill_d  = if_kill;
          state_d = StRdA;
        end
      end
      StRdA: begin
        m_arvalid = 1'b1;
        if (fetch_q && if_kill) kill_d = 1'b1;
        if (m_arready) state_d = StRdD;
      end
      StRdD: begin
        m_rready = 1'b1;
        if (fetch_q && if_kill) kill_d = 1'b1;
        if (m_rvalid) begin
          state_d    = StIdle;
          rsp_data_d = m_rdata;
          rsp_err_d  = (m_rresp != AxiRespOkay);
          // A kill arriving in the handshake cycle itself still suppresses the response.
          if (fetch_q) if_rsp_valid_d = !(kill_q || if_kill);
          else         ls_rsp_valid_d = 1'b1;
        end
      end
      StWrA: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        aw_done_d = aw_done_q || m_awready;
        w_done_d  = w_done_q || m_wready;
        if (aw_done_d && w_done_d) state_d = StWrB;
      end
      StWrB: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          state_d        = StIdle;
          rsp_data_d     = '0;
          rsp_err_d      = (m_bresp != AxiRespOkay);
          ls_rsp_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rrst) begin
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rrst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      size_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      fetch_q        <= 1'b0;
      kill_q         <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      fetch_q        <= fetch_d;
      kill_q         <= kill_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

`ifdef YSYX_22040632_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rrst) begin
      last_ls_q <= 1'b1;
    end else if (grant_if || grant_ls) begin
      last_ls_q <= grant_ls;
    end
  end
`endif

  assign m_araddr     = addr_q;
  assign m_arsize     = size_q;
  assign m_awaddr     = addr_q;
  assign m_awsize     = size_q;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = wstrb_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rsp_err   = rsp_err_q;
  assign ls_rsp_err   = rsp_err_q;
  assign if_rsp_data  = rsp_data_q;
  assign ls_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ysyx_22040632_mem_arbiter.sv
// Directed plus randomized bench for the memory arbiter; the bench acts as both requesters and
// as the AXI slave, one transaction at a time, driving and sampling on the falling clock edge.
module tb_ysyx_22040632_mem_arbiter;

  logic        clk = 1'b0;
  logic        rrst;
  logic        if_req_valid, if_req_ready, if_kill, if_rsp_valid, if_rsp_err;
  logic [31:0] if_req_addr;
  logic [63:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid, ls_rsp_err;
  logic [31:0] ls_req_addr;
  logic [2:0]  ls_req_size;
  logic [63:0] ls_req_wdata, ls_rsp_data;
  logic [7:0]  ls_req_wstrb;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_awaddr;
  logic [2:0]  m_arsize, m_awsize;
  logic [63:0] m_rdata, m_wdata;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [7:0]  m_wstrb;

  int total = 0;
  int bad   = 0;
  bit last_ls = 1'b1;

  always #5 clk = ~clk;

  ysyx_22040632_mem_arbiter dut (
    .clk          (clk),
    .rrst         (rrst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_kill      (if_kill),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_err   (if_rsp_err),
    .if_rsp_data  (if_rsp_data),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_we    (ls_req_we),
    .ls_req_addr  (ls_req_addr),
    .ls_req_size  (ls_req_size),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_wstrb (ls_req_wstrb),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_err   (ls_rsp_err),
    .ls_rsp_data  (ls_rsp_data),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .m_araddr     (m_araddr),
    .m_arsize     (m_arsize),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .m_rdata      (m_rdata),
    .m_rresp      (m_rresp),
    .m_awvalid    (m_awvalid),
    .m_awready    (m_awready),
    .m_awaddr     (m_awaddr),
    .m_awsize     (m_awsize),
    .m_wvalid     (m_wvalid),
    .m_wready     (m_wready),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_bvalid     (m_bvalid),
    .m_bready     (m_bready),
    .m_bresp      (m_bresp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Model of the arbitration rule: which requester wins when both are valid.
  function automatic bit contest_to_ls();
`ifdef YSYX_22040632_ARB_RR_EN
    return !last_ls;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_read(input bit fetch, input logic [31:0] addr, input logic [2:0] size,
                         input int ar_dly, input int r_dly, input logic [1:0] resp,
                         input logic [63:0] data, input int kill_at);
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
    bit          killed;
    int          cyc;
    exp_addr = fetch ? (addr / 8) * 8 : addr;
    exp_size = fetch ? 3'd3 : size;
    killed   = fetch && (kill_at >= 0);
    if (fetch) begin
      if_req_valid = 1'b1;
      if_req_addr  = addr;
    end else begin
      ls_req_valid = 1'b1;
      ls_req_addr  = addr;
      ls_req_size  = size;
      ls_req_we    = 1'b0;
    end
    if_kill = (kill_at == 0);
    #1;
    chk("rd_grant_ready", 64'(fetch ? if_req_ready : ls_req_ready), 64'(1));
    chk("rd_other_ready", 64'(fetch ? ls_req_ready : if_req_ready), 64'(0));
    last_ls = !fetch;
    step();
    cyc = 1;
    if (fetch) if_req_valid = 1'b0;
    else       ls_req_valid = 1'b0;
    chk("rd_rsp_cleared", 64'({if_rsp_valid, ls_rsp_valid}), 64'(0));
    for (int i = 0; i <= ar_dly; i++) begin
      if_kill   = (cyc == kill_at);
      m_arready = (i == ar_dly);
      #1;
      chk("arvalid", 64'(m_arvalid), 64'(1));
      chk("araddr", 64'(m_araddr), 64'(exp_addr));
      chk("busy_ready", 64'({if_req_ready, ls_req_ready}), 64'(0));
      if (i == ar_dly) chk("arsize", 64'(m_arsize), 64'(exp_size));
      step();
      cyc++;
    end
    m_arready = 1'b0;
    for (int i = 0; i <= r_dly; i++) begin
      if_kill = (cyc == kill_at);
      m_rvalid = (i == r_dly);
      m_rdata  = data;
      m_rresp  = resp;
      #1;
      chk("rready", 64'(m_rready), 64'(1));
      chk("arvalid_low", 64'(m_arvalid), 64'(0));
      step();
      cyc++;
    end
    m_rvalid = 1'b0;
    if_kill  = 1'b0;
    chk("if_rsp_valid", 64'(if_rsp_valid), 64'(fetch && !killed));
    chk("ls_rsp_valid", 64'(ls_rsp_valid), 64'(!fetch));
    if (!killed) begin
      chk("rsp_data", fetch ? if_rsp_data : ls_rsp_data, data);
      chk("rsp_err", 64'(fetch ? if_rsp_err : ls_rsp_err), 64'(resp != 2'b00));
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                          input logic [63:0] wdata, input logic [7:0] wstrb, input int aw_dly,
                          input int w_dly, input int b_dly, input logic [1:0] bresp);
    int n;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = addr;
    ls_req_size  = size;
    ls_req_wdata = wdata;
    ls_req_wstrb = wstrb;
    #1;
    chk("wr_grant_ready", 64'(ls_req_ready), 64'(1));
    chk("wr_other_ready", 64'(if_req_ready), 64'(0));
    last_ls = 1'b1;
    step();
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
    chk("wr_rsp_cleared", 64'({if_rsp_valid, ls_rsp_valid}), 64'(0));
    n = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int c = 0; c <= n; c++) begin
      m_awready = (c == aw_dly);
      m_wready  = (c == w_dly);
      #1;
      chk("awvalid", 64'(m_awvalid), 64'(c <= aw_dly));
      chk("wvalid", 64'(m_wvalid), 64'(c <= w_dly));
      chk("bready_low", 64'(m_bready), 64'(0));
      if (c == aw_dly) begin
        chk("awaddr", 64'(m_awaddr), 64'(addr));
        chk("awsize", 64'(m_awsize), 64'(size));
      end
      if (c == w_dly) begin
        chk("wdata", m_wdata, wdata);
        chk("wstrb", 64'(m_wstrb), 64'(wstrb));
      end
      step();
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    for (int i = 0; i <= b_dly; i++) begin
      m_bvalid = (i == b_dly);
      m_bresp  = bresp;
      #1;
      chk("bready", 64'(m_bready), 64'(1));
      chk("wr_valids_low", 64'({m_awvalid, m_wvalid}), 64'(0));
      step();
    end
    m_bvalid = 1'b0;
    chk("wr_ls_rsp_valid", 64'(ls_rsp_valid), 64'(1));
    chk("wr_if_rsp_valid", 64'(if_rsp_valid), 64'(0));
    chk("wr_rsp_data", ls_rsp_data, 64'(0));
    chk("wr_rsp_err", 64'(ls_rsp_err), 64'(bresp != 2'b00));
  endtask

  // Both requesters raise valid; the model picks the winner and only the winner is served.
  task automatic contest(input logic [31:0] faddr, input logic [31:0] laddr);
    if_req_valid = 1'b1;
    if_req_addr  = faddr;
    ls_req_valid = 1'b1;
    ls_req_addr  = laddr;
    ls_req_we    = 1'b0;
    if (contest_to_ls()) do_read(1'b0, laddr, 3'd2, 0, 0, 2'b00, {32'h0, laddr}, -1);
    else                 do_read(1'b1, faddr, 3'd3, 0, 0, 2'b00, {faddr, 32'h0}, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0; if_kill = 1'b0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0; ls_req_size = '0;
    ls_req_wdata = '0; ls_req_wstrb = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
    step();
    step();
    chk("rst_m_valids", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'(0));
    chk("rst_m_readies", 64'({m_rready, m_bready}), 64'(0));
    chk("rst_rsp_valid", 64'({if_rsp_valid, ls_rsp_valid}), 64'(0));
    chk("rst_rsp_err", 64'({if_rsp_err, ls_rsp_err}), 64'(0));
    chk("rst_rsp_data", if_rsp_data, 64'(0));
    chk("rst_araddr", 64'(m_araddr), 64'(0));
    rrst = 1'b0;
    last_ls = 1'b1;
    step();

    // Aligned fetch with zero-wait slave.
    do_read(1'b1, 32'h8000_0004, 3'd0, 0, 0, 2'b00, 64'h1122_3344_5566_7788, -1);

    // Three back-to-back contests, then serve whoever is still waiting.
    contest(32'h8000_0100, 32'h2000_0000);
    contest(32'h8000_0108, 32'h2000_0008);
    contest(32'h8000_0110, 32'h2000_0010);
    if (if_req_valid) do_read(1'b1, if_req_addr, 3'd3, 0, 0, 2'b00, {if_req_addr, 32'h0}, -1);
    if (ls_req_valid) do_read(1'b0, ls_req_addr, 3'd2, 0, 0, 2'b00, {32'h0, ls_req_addr}, -1);

    // Write: wready at once, awready three cycles later, SLVERR response.
    do_write(32'h1000_0000, 3'd2, 64'hdead_beef_cafe_f00d, 8'h0f, 3, 0, 0, 2'b10);

    // Kill while waiting in the data phase, then a normal fetch.
    do_read(1'b1, 32'h8000_0200, 3'd3, 0, 5, 2'b00, 64'h0bad_0bad_0bad_0bad, 3);
    do_read(1'b1, 32'h8000_0208, 3'd3, 0, 0, 2'b00, 64'h600d_600d_600d_600d, -1);
    // Kill in the grant cycle itself.
    do_read(1'b1, 32'h8000_0210, 3'd3, 1, 1, 2'b00, 64'h1, 0);

    // Reset while a write is in its address phase.
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h3000_0000;
    ls_req_size = 3'd3; ls_req_wdata = 64'h5; ls_req_wstrb = 8'hff;
    #1;
    chk("rstwr_grant", 64'(ls_req_ready), 64'(1));
    step();
    ls_req_valid = 1'b0; ls_req_we = 1'b0;
    #1;
    chk("rstwr_awvalid", 64'(m_awvalid), 64'(1));
    rrst = 1'b1;
    step();
    chk("rstwr_valids", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'(0));
    chk("rstwr_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'(0));
    rrst = 1'b0;
    last_ls = 1'b1;
    do_read(1'b0, 32'h3000_0040, 3'd3, 0, 0, 2'b00, 64'h7777_0000_7777_0000, -1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int          kind, ar, r, kat;
      logic [31:0] a;
      logic [63:0] d;
      logic [1:0]  rs;
      kind = int'($urandom_range(0, 2));
      ar   = int'($urandom_range(0, 3));
      r    = int'($urandom_range(0, 3));
      a    = $urandom;
      d    = {$urandom, $urandom};
      rs   = 2'($urandom_range(0, 3));
      if (kind == 0) begin
        kat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 + ar + r)) : -1;
        do_read(1'b1, a, 3'd3, ar, r, rs, d, kat);
      end else if (kind == 1) begin
        do_read(1'b0, a, 3'($urandom_range(0, 3)), ar, r, rs, d, -1);
      end else begin
        do_write(a, 3'($urandom_range(0, 3)), d, 8'($urandom), ar, r,
                 int'($urandom_range(0, 3)), rs);
      end
      if ($urandom_range(0, 2) == 0) begin
        step();
        chk("idle_no_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'(0));
      end
    end

    step();
    chk("final_no_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
